// File: rtl/mem_responder_pkg.sv
// Shared types for the multi-channel memory responder: per-channel FSM
// states and the kind of operation a channel is currently servicing.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP_RD,
    RESP_WR
  } resp_state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

endpackage : mem_responder_pkg

// File: rtl/mem_responder_channel.sv
// One request channel: accepts a read or write, waits a fixed latency, then
// flags completion to the top and holds ready until the requester drops valid.
module mem_responder_channel
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_valid,
  input  logic [ADDR_BITS-1:0] read_address,
  input  logic                 write_valid,
  input  logic [ADDR_BITS-1:0] write_address,
  input  logic [DATA_BITS-1:0] write_data,
  output logic                 read_ready,
  output logic                 write_ready,
  output logic                 commit_wr,
  output logic                 sample_rd,
  output logic [ADDR_BITS-1:0] addr,
  output logic [DATA_BITS-1:0] wdata
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  resp_state_t          state_q, state_d;
  op_t                  op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;

  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    commit_wr = 1'b0;
    sample_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Read wins a tie; the write stays pending on write_valid.
        if (read_valid) begin
          addr_d  = read_address;
          op_d    = OP_RD;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end else if (write_valid) begin
          addr_d  = write_address;
          wdata_d = write_data;
          op_d    = OP_WR;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          if (op_q == OP_RD) begin
            sample_rd = 1'b1;
            state_d   = RESP_RD;
          end else begin
            commit_wr = 1'b1;
            state_d   = RESP_WR;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP_RD: if (!read_valid) state_d = IDLE;
      RESP_WR: if (!write_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign read_ready  = (state_q == RESP_RD);
  assign write_ready = (state_q == RESP_WR);
  assign addr        = addr_q;
  assign wdata       = wdata_q;

endmodule : mem_responder_channel

// File: rtl/mem_responder.sv
// Memory end of the mem_if valid/ready protocol: CHANNELS independent
// channels sharing one array, plus a preload port that outranks them all.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CHANNELS-1:0]                 read_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  read_address,
  output logic [CHANNELS-1:0]                 read_ready,
  output logic [CHANNELS-1:0][DATA_BITS-1:0]  read_data,
  input  logic [CHANNELS-1:0]                 write_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  write_address,
  input  logic [CHANNELS-1:0][DATA_BITS-1:0]  write_data,
  output logic [CHANNELS-1:0]                 write_ready,
  input  logic                                load_enable,
  input  logic [ADDR_BITS-1:0]                load_address,
  input  logic [DATA_BITS-1:0]                load_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0]                mem_q [DEPTH];
  logic [DATA_BITS-1:0]                mem_d [DEPTH];
  logic [CHANNELS-1:0][DATA_BITS-1:0]  rdata_q, rdata_d;
  logic [CHANNELS-1:0]                 commit_wr, sample_rd;
  logic [CHANNELS-1:0][ADDR_BITS-1:0]  ch_addr;
  logic [CHANNELS-1:0][DATA_BITS-1:0]  ch_wdata;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    mem_responder_channel #(
      .ADDR_BITS(ADDR_BITS),
      .DATA_BITS(DATA_BITS),
      .LATENCY  (LATENCY)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .read_valid   (read_valid[g]),
      .read_address (read_address[g]),
      .write_valid  (write_valid[g]),
      .write_address(write_address[g]),
      .write_data   (write_data[g]),
      .read_ready   (read_ready[g]),
      .write_ready  (write_ready[g]),
      .commit_wr    (commit_wr[g]),
      .sample_rd    (sample_rd[g]),
      .addr         (ch_addr[g]),
      .wdata        (ch_wdata[g])
    );
  end

  // Applied highest channel first so the lowest-index writer lands last
  // and wins a shared row; preload is applied after all of them.
  always_comb begin
    mem_d = mem_q;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (commit_wr[i]) mem_d[ch_addr[i]] = ch_wdata[i];
    end
    if (load_enable) mem_d[load_address] = load_data;
  end

  // Reads sample the registered array, so a same-cycle write is not seen.
  always_comb begin
    rdata_d = rdata_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sample_rd[i]) rdata_d[i] = mem_q[ch_addr[i]];
    end
  end

  // NOTE: the array is built from resettable flops because every row must
  // read back as zero after reset; a RAM macro could not offer that.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q   <= '{default: '0};
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign read_data = rdata_q;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// Directed and randomized checks of mem_responder against a transaction-level
// memory model (flat array, lowest-channel-wins writes, pre-write reads).
module tb_mem_responder;

  localparam int LAT = 2;
  localparam int NCH = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       read_valid, write_valid, read_ready, write_ready;
  logic [NCH-1:0][7:0]  read_address, write_address, write_data, read_data;
  logic                 load_enable;
  logic [7:0]           load_address, load_data;

  logic [7:0] model_mem [256];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(NCH), .LATENCY(LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .read_valid   (read_valid),
    .read_address (read_address),
    .read_ready   (read_ready),
    .read_data    (read_data),
    .write_valid  (write_valid),
    .write_address(write_address),
    .write_data   (write_data),
    .write_ready  (write_ready),
    .load_enable  (load_enable),
    .load_address (load_address),
    .load_data    (load_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int ch, input bit is_rd, output int n);
    n = 0;
    while (n < 20 && !(is_rd ? read_ready[ch] : write_ready[ch])) begin
      tick();
      n++;
    end
  endtask

  task automatic do_read(input int ch, input logic [7:0] a, input logic [7:0] exp, input string tag);
    int n;
    read_valid[ch]   = 1'b1;
    read_address[ch] = a;
    tick();
    wait_ready(ch, 1'b1, n);
    check({tag, "_lat"}, n, LAT);
    check({tag, "_data"}, read_data[ch], exp);
    read_valid[ch] = 1'b0;
    tick();
    check({tag, "_fall"}, read_ready[ch], 0);
  endtask

  task automatic do_write(input int ch, input logic [7:0] a, input logic [7:0] d, input string tag);
    int n;
    write_valid[ch]   = 1'b1;
    write_address[ch] = a;
    write_data[ch]    = d;
    tick();
    wait_ready(ch, 1'b0, n);
    check({tag, "_lat"}, n, LAT);
    write_valid[ch] = 1'b0;
    tick();
    check({tag, "_fall"}, write_ready[ch], 0);
    model_mem[a] = d;
  endtask

  initial begin
    int   n, highs, first_hi;
    bit   is_wr [NCH];
    bit   win;
    logic [7:0] ra [NCH];
    logic [7:0] rd [NCH];

    reset = 1'b0;
    read_valid = '0; write_valid = '0;
    read_address = '0; write_address = '0; write_data = '0;
    load_enable = 1'b0; load_address = '0; load_data = '0;
    for (int r = 0; r < 256; r++) model_mem[r] = 8'h00;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("reset_rd_ready", read_ready, 0);
    check("reset_wr_ready", write_ready, 0);
    check("reset_rd_data", read_data, 0);

    // Preload, then read it back through channel 0.
    load_enable = 1'b1; load_address = 8'h10; load_data = 8'hA5;
    tick();
    load_enable = 1'b0;
    model_mem[8'h10] = 8'hA5;
    do_read(0, 8'h10, 8'hA5, "preload_rd");

    // Write on one channel, read on another.
    do_write(1, 8'h20, 8'h3C, "ch1_wr");
    do_read(2, 8'h20, 8'h3C, "ch2_rd");

    // Two channels write the same row in the same cycle: lower index wins.
    write_valid[0] = 1'b1; write_address[0] = 8'h05; write_data[0] = 8'h11;
    write_valid[3] = 1'b1; write_address[3] = 8'h05; write_data[3] = 8'h22;
    tick();
    wait_ready(0, 1'b0, n);
    check("coll_lat", n, LAT);
    check("coll_ch3_ready", write_ready[3], 1);
    write_valid[0] = 1'b0; write_valid[3] = 1'b0;
    tick();
    check("coll_fall", write_ready, 0);
    model_mem[8'h05] = 8'h11;
    do_read(2, 8'h05, 8'h11, "coll_rd");

    // Read and write requested together on one channel: read first.
    read_valid[0] = 1'b1;  read_address[0] = 8'h30;
    write_valid[0] = 1'b1; write_address[0] = 8'h30; write_data[0] = 8'h5A;
    tick();
    wait_ready(0, 1'b1, n);
    check("both_rd_lat", n, LAT);
    check("both_rd_data", read_data[0], model_mem[8'h30]);
    check("both_no_wr_ready", write_ready[0], 0);
    read_valid[0] = 1'b0;
    tick();
    check("both_gap", {read_ready[0], write_ready[0]}, 0);
    tick();
    wait_ready(0, 1'b0, n);
    check("both_wr_lat", n, LAT);
    write_valid[0] = 1'b0;
    tick();
    model_mem[8'h30] = 8'h5A;
    do_read(1, 8'h30, 8'h5A, "both_rd_back");

    // Valid dropped while busy: ready still pulses for exactly one cycle.
    read_valid[0] = 1'b1; read_address[0] = 8'h10;
    tick();
    read_valid[0] = 1'b0;
    highs = 0; first_hi = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (read_ready[0]) begin
        highs++;
        if (first_hi == 0) first_hi = k;
      end
    end
    check("abort_pulses", highs, 1);
    check("abort_when", first_hi, LAT);
    check("abort_data", read_data[0], 8'hA5);
    do_read(0, 8'h20, 8'h3C, "abort_next_rd");

    // Random concurrent traffic on all channels over a small row range.
    for (int it = 0; it < 24; it++) begin
      for (int c = 0; c < NCH; c++) begin
        is_wr[c] = 1'($urandom_range(0, 1));
        ra[c]    = 8'($urandom_range(0, 7));
        rd[c]    = 8'($urandom);
        read_valid[c]    = !is_wr[c];
        write_valid[c]   = is_wr[c];
        read_address[c]  = ra[c];
        write_address[c] = ra[c];
        write_data[c]    = rd[c];
      end
      tick();
      for (int k = 1; k < LAT; k++) begin
        tick();
        check("rand_early", {read_ready, write_ready}, 0);
      end
      tick();
      for (int c = 0; c < NCH; c++) begin
        check("rand_ready", {read_ready[c], write_ready[c]}, is_wr[c] ? 2'b01 : 2'b10);
        if (!is_wr[c]) check("rand_rd_data", read_data[c], model_mem[ra[c]]);
      end
      for (int c = 0; c < NCH; c++) begin
        win = is_wr[c];
        for (int j = 0; j < c; j++) if (is_wr[j] && ra[j] == ra[c]) win = 1'b0;
        if (win) model_mem[ra[c]] = rd[c];
      end
      read_valid = '0; write_valid = '0;
      tick();
      check("rand_fall", {read_ready, write_ready}, 0);
    end
    for (int r = 0; r < 8; r++) do_read(r % NCH, 8'(r), model_mem[r], "sweep_rd");

    // Reset while a write is in flight: it must never land.
    write_valid[0] = 1'b1; write_address[0] = 8'h40; write_data[0] = 8'h77;
    tick();
    reset = 1'b0;
    #1;
    check("rst_rd_ready", read_ready, 0);
    check("rst_wr_ready", write_ready, 0);
    check("rst_rd_data", read_data, 0);
    write_valid[0] = 1'b0;
    for (int r = 0; r < 256; r++) model_mem[r] = 8'h00;
    tick();
    reset = 1'b1;
    tick();
    do_read(0, 8'h40, 8'h00, "rst_rd_40");
    do_read(3, 8'h10, 8'h00, "rst_rd_10");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_responder
